// File: rtl/fp_add_pkg.sv
// Shared constants and stage-3 payload type for the single-precision FP adder pipeline.
package fp_add_pkg;

  localparam int unsigned MAN_W = 24;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned SUM_W = MAN_W + 1;

  typedef struct packed {
    logic [SUM_W-1:0] sum_man;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
  } s3_payload_t;

endpackage

// File: rtl/fp_mag_addsub.sv
// Combinational signed-magnitude add/subtract of aligned mantissas with result sign and cancellation flag.
module fp_mag_addsub
  import fp_add_pkg::*;
(
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic [SUM_W-1:0] sum_c,
  output logic             sign_c,
  output logic             zero_c
);

  // Subtract the smaller magnitude from the larger so the difference never carries out.
  always_comb begin
    sum_c  = '0;
    sign_c = sign_a;
    zero_c = 1'b0;
    if (sign_a == sign_b) begin
      sum_c = SUM_W'(man_a) + SUM_W'(man_b);
    end else if (man_a > man_b) begin
      sum_c = SUM_W'(man_a - man_b);
    end else if (man_a < man_b) begin
      sum_c  = SUM_W'(man_b - man_a);
      sign_c = sign_b;
    end else begin
      zero_c = 1'b1;
      sign_c = 1'b0;
    end
  end

endmodule

// File: rtl/fp_add_stage3_mantissa_addsub.sv
// FP adder stage 3: mantissa add/subtract behind a two-entry skid pipeline.
// Optional FP_ADD_ZERO_FLAG_EN adds zero_res and forces exp_out to 0 on exact cancellation.
module fp_add_stage3_mantissa_addsub
  import fp_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_man,
  output logic [EXP_W-1:0] exp_out,
  output logic             sum_sign
`ifdef FP_ADD_ZERO_FLAG_EN
  ,
  output logic             zero_res
`endif
);

  logic [SUM_W-1:0] mag_sum;
  logic             mag_sign;
  logic             mag_zero;

  s3_payload_t new_pl_c;
  s3_payload_t main_q, main_d;
  s3_payload_t skid_q, skid_d;
  logic        main_vld_q, main_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic        in_fire_c;
  logic        out_fire_c;

  fp_mag_addsub u_mag (
    .man_a  (man_a),
    .man_b  (man_b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .sum_c  (mag_sum),
    .sign_c (mag_sign),
    .zero_c (mag_zero)
  );

  // Payload assembled from the arithmetic result ahead of the registers.
  always_comb begin
    new_pl_c         = '0;
    new_pl_c.sum_man = mag_sum;
    new_pl_c.sign    = mag_sign;
`ifdef FP_ADD_ZERO_FLAG_EN
    new_pl_c.zero    = mag_zero;
    new_pl_c.exp     = mag_zero ? '0 : exp_in;
`else
    new_pl_c.zero    = 1'b0;
    new_pl_c.exp     = exp_in;
`endif
  end

`ifndef FP_ADD_ZERO_FLAG_EN
  logic unused_zero;
  assign unused_zero = mag_zero ^ main_q.zero;
`endif

  assign in_ready   = ~skid_vld_q;
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = main_vld_q & out_ready;

  // Skid control: main refills from skid first so ordering is preserved.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_fire_c) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_fire_c;
        if (in_fire_c) begin
          skid_d = new_pl_c;
        end
      end else begin
        main_vld_d = in_fire_c;
        if (in_fire_c) begin
          main_d = new_pl_c;
        end
      end
    end else if (in_fire_c) begin
      skid_d     = new_pl_c;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid = main_vld_q;
  assign sum_man   = main_q.sum_man;
  assign exp_out   = main_q.exp;
  assign sum_sign  = main_q.sign;
`ifdef FP_ADD_ZERO_FLAG_EN
  assign zero_res  = main_q.zero;
`endif

endmodule

// File: tb/tb_fp_add_stage3_mantissa_addsub.sv
// Scoreboard bench for FP adder stage 3: directed cases, backpressure, mid-stall reset, random stream.
module tb_fp_add_stage3_mantissa_addsub;
  import fp_add_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic             sign_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum_man;
  logic [EXP_W-1:0] exp_out;
  logic             sum_sign;
`ifdef FP_ADD_ZERO_FLAG_EN
  logic             zero_res;
`endif

  s3_payload_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fp_add_stage3_mantissa_addsub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .man_a     (man_a),
    .man_b     (man_b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_man   (sum_man),
    .exp_out   (exp_out),
    .sum_sign  (sum_sign)
`ifdef FP_ADD_ZERO_FLAG_EN
    ,
    .zero_res  (zero_res)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: signed integer sum of the two signed magnitudes.
  function automatic s3_payload_t model(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                                        input logic sa, input logic sb, input logic [EXP_W-1:0] e);
    int va;
    int vb;
    int r;
    s3_payload_t p;
    va = int'({8'b0, a});
    vb = int'({8'b0, b});
    if (sa) va = -va;
    if (sb) vb = -vb;
    r = va + vb;
    p.sum_man = SUM_W'((r < 0) ? -r : r);
    if (r < 0)      p.sign = 1'b1;
    else if (r > 0) p.sign = 1'b0;
    else            p.sign = (sa == sb) ? sa : 1'b0;
    p.exp  = e;
    p.zero = 1'b0;
`ifdef FP_ADD_ZERO_FLAG_EN
    p.zero = (sa != sb) && (a == b);
    if (p.zero) p.exp = '0;
`endif
    return p;
  endfunction

  // Evaluate transfers for the upcoming edge, then advance one cycle.
  task automatic tick();
    s3_payload_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sum_man", 32'(sum_man), 32'(e.sum_man));
        check_eq("exp_out", 32'(exp_out), 32'(e.exp));
        check_eq("sum_sign", 32'(sum_sign), 32'(e.sign));
`ifdef FP_ADD_ZERO_FLAG_EN
        check_eq("zero_res", 32'(zero_res), 32'(e.zero));
`endif
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(man_a, man_b, sign_a, sign_b, exp_in));
    @(negedge clk);
  endtask

  task automatic drive(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                       input logic sa, input logic sb, input logic [EXP_W-1:0] e);
    man_a  = a;
    man_b  = b;
    sign_a = sa;
    sign_b = sb;
    exp_in = e;
  endtask

  task automatic directed(input string tag, input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                          input logic sa, input logic sb, input logic [EXP_W-1:0] e,
                          input logic [SUM_W-1:0] want_sum, input logic want_sign,
                          input logic [EXP_W-1:0] want_exp);
    drive(a, b, sa, sb, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_sum"}, 32'(sum_man), 32'(want_sum));
    check_eq({tag, "_sign"}, 32'(sum_sign), 32'(want_sign));
    check_eq({tag, "_exp"}, 32'(exp_out), 32'(want_exp));
    tick();
    check_eq({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  logic [MAN_W-1:0] bp_a [4];
  logic             acc;
  logic             pend;
  int               idx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, '0);
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum_man", 32'(sum_man), 32'd0);
    check_eq("rst_exp_out", 32'(exp_out), 32'd0);
    check_eq("rst_sum_sign", 32'(sum_sign), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    directed("add_eq", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'h7F, 25'h1000000, 1'b0, 8'h7F);
    directed("sub_blarge", 24'hC00000, 24'hE00000, 1'b0, 1'b1, 8'h80, 25'h0200000, 1'b1, 8'h80);
`ifdef FP_ADD_ZERO_FLAG_EN
    directed("cancel", 24'hA00000, 24'hA00000, 1'b1, 1'b0, 8'h85, 25'h0, 1'b0, 8'h00);
`else
    directed("cancel", 24'hA00000, 24'hA00000, 1'b1, 1'b0, 8'h85, 25'h0, 1'b0, 8'h85);
`endif

    // Backpressure: four payloads against a stalled consumer, then release.
    bp_a[0] = 24'h900001; bp_a[1] = 24'h900002; bp_a[2] = 24'h900003; bp_a[3] = 24'h900004;
    out_ready = 1'b0;
    idx = 0;
    drive(bp_a[0], 24'h100000, 1'b0, 1'b0, 8'h10);
    in_valid = 1'b1;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      acc = in_valid && in_ready;
      if (c == 2) begin
        check_eq("bp_in_ready_full", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid_held", 32'(out_valid), 32'd1);
      end
      if (c == 4) out_ready = 1'b1;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) drive(bp_a[idx], 24'h100000, 1'b0, 1'b0, 8'(8'h10 + idx));
        else in_valid = 1'b0;
      end
    end
    check_eq("bp_drain", 32'(exp_q.size()), 32'd0);

    // Reset while main and skid both hold data.
    out_ready = 1'b0;
    drive(24'h123456, 24'h654321, 1'b0, 1'b1, 8'h33);
    in_valid = 1'b1;
    tick();
    drive(24'h0ABCDE, 24'h111111, 1'b1, 1'b1, 8'h44);
    tick();
    in_valid = 1'b0;
    check_eq("mid_full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_sum_man", 32'(sum_man), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    directed("post_rst", 24'h400000, 24'h200000, 1'b1, 1'b1, 8'h55, 25'h0600000, 1'b1, 8'h55);

    // Random stream with random backpressure.
    in_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      pend = in_valid && !in_ready;
      tick();
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        man_a    = MAN_W'($urandom);
        man_b    = ($urandom_range(0, 7) == 0) ? man_a : MAN_W'($urandom);
        sign_a   = 1'($urandom);
        sign_b   = 1'($urandom);
        exp_in   = EXP_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    check_eq("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_stage3_mantissa_addsub.md
Name: fp_add_stage3_mantissa_addsub

Overview:
- Stage 3 of the 4-stage single-precision FP adder pipeline.
- Takes exponent-aligned mantissas from Stage 2 (align/shift).
- Performs signed-magnitude add or subtract and produces the result sign.
- Presents the 25-bit raw sum, common exponent and sign to Stage 4 (normalize) over a valid/ready handshake, so the pipeline can stall without losing data.

Parameters:
- MAN_W, 24: mantissa width including hidden bit. sum_man is MAN_W+1 bits.
- EXP_W, 8: exponent width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  Stage 2 payload valid.
- in_ready  out  1  stage can accept payload this cycle.
- man_a  in  MAN_W  aligned mantissa of operand A, hidden bit at MSB.
- man_b  in  MAN_W  aligned mantissa of operand B, hidden bit at MSB.
- sign_a  in  1  sign of A.
- sign_b  in  1  effective sign of B; Stage 2 has already folded the subtract opcode into it.
- exp_in  in  EXP_W  common (larger) exponent.
- out_valid  out  1  payload to Stage 4 valid.
- out_ready  in  1  Stage 4 accepts the payload.
- sum_man  out  MAN_W+1  raw magnitude sum/difference; bit MAN_W is the carry-out.
- exp_out  out  EXP_W  exp_in passed through unchanged.
- sum_sign  out  1  result sign.
- zero_res  out  1  exact-cancellation flag; present only when FP_ADD_ZERO_FLAG_EN is defined.

Behaviour:
- Reset (async, rst=1): out_valid=0, sum_man=0, exp_out=0, sum_sign=0, zero_res=0, skid buffer empty, in_ready=1. Inputs are ignored while rst=1.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Payload is held stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid, with no stall. Throughput is 1 per cycle.
- Buffering uses a two-entry skid structure (main output register + skid register):
  - in_ready is registered: in_ready = !skid_valid.
  - If an input transfer occurs while the main register is full and not draining, the payload goes to the skid register.
  - When the main register drains, the skid entry moves to main in the same cycle; a simultaneous new input then goes to skid. Order is preserved.
  - Simultaneous input and output transfer with an empty skid: main is overwritten with the new payload and out_valid stays 1.
  - Full (main + skid valid): in_ready=0. in_valid is ignored.
- Arithmetic (combinational, before the register):
  - sign_a == sign_b: sum = {1'b0,man_a} + {1'b0,man_b}; sign = sign_a.
  - Signs differ, man_a >= man_b: sum = man_a - man_b; sign = sign_a.
  - Signs differ, man_a < man_b: sum = man_b - man_a; sign = sign_b.
  - Exact cancellation (signs differ, man_a == man_b): sum = 0; sign forced to 0 (+0, round-to-nearest).
  - The difference never sets bit MAN_W.
- exp_out = exp_in, registered alongside the payload. No exponent arithmetic happens in this stage.
- Reset mid-stall: all buffered payloads are discarded; outputs return to reset values asynchronously.

Optional Feature:
- Macro FP_ADD_ZERO_FLAG_EN.
- Defined:
  - Port zero_res exists; it is registered with the payload and is 1 exactly on cancellation.
  - On cancellation, exp_out is forced to 0 so Stage 4 emits a clean +0.0.
- Undefined:
  - zero_res is absent.
  - exp_out always equals exp_in; cancellation yields sum_man=0 with the original exponent.

Decomposition:
- Shared package fp_add_pkg:
  - constants MAN_W=24, EXP_W=8, SUM_W=MAN_W+1;
  - typedef s3_payload_t {sum_man, exp, sign, zero}, used for both the main and skid registers.
- One natural sub-module: fp_mag_addsub, a purely combinational compare/add/subtract producing {sum, sign, zero}. The stage wraps it with the skid pipeline.

Test Plan:
- Equal signs:
  - man_a=24'h800000, man_b=24'h800000, exp_in=8'h7F, signs 0 (1.0+1.0) -> one cycle later out_valid=1, sum_man=25'h1000000, exp_out=8'h7F, sum_sign=0.
- Subtract, B larger:
  - man_a=24'hC00000, sign_a=0, man_b=24'hE00000, sign_b=1 -> sum_man=25'h0200000, sum_sign=1.
- Cancellation:
  - man_a=man_b=24'hA00000, sign_a=1, sign_b=0 -> sum_man=0, sum_sign=0.
  - With FP_ADD_ZERO_FLAG_EN: zero_res=1, exp_out=0.
- Backpressure:
  - Stream 4 back-to-back payloads, hold out_ready=0 from cycle 1 -> main and skid capture payloads 1 and 2; in_ready=0 from the next cycle; no payload lost or reordered.
  - Release out_ready -> payloads appear in order 1,2,3,4 on consecutive cycles.
- Reset mid-operation:
  - Assert rst asynchronously while main and skid are full -> out_valid=0, sum_man=0 immediately; in_ready=1 after release; the first post-reset payload emerges alone.
- Random:
  - 10k random operand pairs with random out_ready toggling -> scoreboard matches the reference magnitude add/sub model exactly and in order.
